// File: rtl/sysid_checker.sv
// Reads the system ID (address 0) and build timestamp (address 1) from a sysid
// slave over Avalon-MM, compares both against the build-time expectations and reports.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1378862049,
  parameter int unsigned READ_LATENCY = 32'd0,
  parameter int unsigned TIMEOUT      = 32'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    FIN    = 3'd5
  } state_e;

  localparam logic [1:0]  LAT_N  = 2'(READ_LATENCY);
  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);
  localparam bit          LAT0   = (READ_LATENCY == 32'd0);

  state_e      state_q, state_d;
  logic [15:0] to_q, to_d;
  logic [1:0]  lat_q, lat_d;
  logic [16:0] to_inc_s;
  logic        tmo_hit_s;
  logic        cap_id_s, cap_ts_s, tmo_s, clear_s;
  logic        avm_read_q, avm_read_d, avm_address_q, avm_address_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        id_ok_q, ts_ok_q, timeout_err_q;
  logic        id_cap_q, ts_cap_q;
  logic [31:0] captured_id_q, captured_ts_q;

  assign to_inc_s  = {1'b0, to_q} + 17'd1;
  // A capture in the cycle the budget runs out takes priority over the abort.
  assign tmo_hit_s = (to_inc_s >= TO_LIM);

  // Next-state, per-read counters and registered-output decode
  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    lat_d    = lat_q;
    cap_id_s = 1'b0;
    cap_ts_s = 1'b0;
    tmo_s    = 1'b0;
    clear_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          clear_s = 1'b1;
          to_d    = 16'd0;
          lat_d   = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest && LAT0) begin
          if (state_q == RD_ID) begin
            cap_id_s = 1'b1;
            state_d  = RD_TS;
            to_d     = 16'd0;
          end else begin
            cap_ts_s = 1'b1;
            state_d  = FIN;
          end
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_d = FIN;
        end else if (!avm_waitrequest) begin
          state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          lat_d   = 2'd1;
          to_d    = to_inc_s[15:0];
        end else begin
          to_d = to_inc_s[15:0];
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_q == LAT_N) begin
          if (state_q == LAT_ID) begin
            cap_id_s = 1'b1;
            state_d  = RD_TS;
            to_d     = 16'd0;
          end else begin
            cap_ts_s = 1'b1;
            state_d  = FIN;
          end
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_d = FIN;
        end else begin
          lat_d = lat_q + 2'd1;
          to_d  = to_inc_s[15:0];
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = (state_d == RD_TS);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == FIN);
  end

  // State, counters and bus/handshake output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      to_q          <= 16'd0;
      lat_q         <= 2'd0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_q          <= to_d;
      lat_q         <= lat_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Captured data, error flag and the compare stage one cycle behind each capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      captured_id_q <= 32'd0;
      captured_ts_q <= 32'd0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      id_cap_q      <= 1'b0;
      ts_cap_q      <= 1'b0;
    end else if (clear_s) begin
      captured_id_q <= 32'd0;
      captured_ts_q <= 32'd0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      id_cap_q      <= 1'b0;
      ts_cap_q      <= 1'b0;
    end else begin
      id_cap_q <= cap_id_s;
      ts_cap_q <= cap_ts_s;
      if (cap_id_s) captured_id_q <= avm_readdata;
      if (cap_ts_s) captured_ts_q <= avm_readdata;
      if (tmo_s) timeout_err_q <= 1'b1;
      if (id_cap_q) id_ok_q <= (captured_id_q == EXPECTED_ID);
      if (ts_cap_q) ts_ok_q <= (captured_ts_q == EXPECTED_TS);
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_err_q;
  assign captured_id = captured_id_q;
  assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: three instances (latency 0, latency 2, short timeout) driven
// by a modelled sysid slave and checked against a per-read cycle/outcome model.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1378862049;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start [3];
  logic        addr [3];
  logic        rd [3];
  logic [31:0] rdata [3];
  logic        wr [3];
  logic        busy [3];
  logic        done [3];
  logic        id_ok [3];
  logic        ts_ok [3];
  logic        terr [3];
  logic [31:0] cid [3];
  logic [31:0] cts [3];

  int          hcnt [3];
  int          dly [3];
  logic        daddr [3];
  logic [31:0] garb [3];
  int          stall_id [3];
  int          stall_ts [3];
  logic [31:0] id_val [3];
  logic [31:0] ts_val [3];
  int          rd1_cnt [3];
  int          stab_err [3];
  logic        prev_hold [3];
  logic        prev_addr [3];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int to_of(input int k);
    return (k == 2) ? 4 : 255;
  endfunction

  sysid_checker #(.EXPECTED_ID(32'd0), .EXPECTED_TS(32'd1378862049), .READ_LATENCY(0), .TIMEOUT(255)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
    .avm_readdata(rdata[0]), .avm_waitrequest(wr[0]), .busy(busy[0]), .done(done[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout_err(terr[0]), .captured_id(cid[0]), .captured_ts(cts[0]));

  sysid_checker #(.EXPECTED_ID(32'd0), .EXPECTED_TS(32'd1378862049), .READ_LATENCY(2), .TIMEOUT(255)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
    .avm_readdata(rdata[1]), .avm_waitrequest(wr[1]), .busy(busy[1]), .done(done[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout_err(terr[1]), .captured_id(cid[1]), .captured_ts(cts[1]));

  sysid_checker #(.EXPECTED_ID(32'd0), .EXPECTED_TS(32'd1378862049), .READ_LATENCY(0), .TIMEOUT(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start[2]), .avm_address(addr[2]), .avm_read(rd[2]),
    .avm_readdata(rdata[2]), .avm_waitrequest(wr[2]), .busy(busy[2]), .done(done[2]),
    .id_ok(id_ok[2]), .ts_ok(ts_ok[2]), .timeout_err(terr[2]), .captured_id(cid[2]), .captured_ts(cts[2]));

  // Slave model: stall per address, data only on the delivery cycle, random garbage otherwise
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      wr[k]    = rd[k] && (hcnt[k] < (addr[k] ? stall_ts[k] : stall_id[k]));
      rdata[k] = garb[k];
      if (lat_of(k) == 0) begin
        if (rd[k] && !wr[k]) rdata[k] = addr[k] ? ts_val[k] : id_val[k];
      end else if (dly[k] == 1) begin
        rdata[k] = daddr[k] ? ts_val[k] : id_val[k];
      end
    end
  end

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        hcnt[k]      <= 0;
        dly[k]       <= 0;
        daddr[k]     <= 1'b0;
        garb[k]      <= $urandom;
        prev_hold[k] <= 1'b0;
        prev_addr[k] <= 1'b0;
      end else begin
        garb[k] <= $urandom;
        if (rd[k] && !wr[k]) begin
          hcnt[k] <= 0;
          if (lat_of(k) > 0) begin
            dly[k]   <= lat_of(k);
            daddr[k] <= addr[k];
          end
        end else begin
          hcnt[k] <= rd[k] ? hcnt[k] + 1 : 0;
          if (dly[k] > 0) dly[k] <= dly[k] - 1;
        end
        if (rd[k] && addr[k]) rd1_cnt[k] <= rd1_cnt[k] + 1;
        if (prev_hold[k] && ((rd[k] && addr[k] != prev_addr[k]) || (!rd[k] && !terr[k])))
          stab_err[k] <= stab_err[k] + 1;
        prev_hold[k] <= rd[k] && wr[k];
        prev_addr[k] <= addr[k];
      end
    end
  end

  // One sequence on instance k; expected timing/outcome from per-read cycle arithmetic.
  task automatic run_seq(input int k, input logic [31:0] idv, input logic [31:0] tsv,
                         input int sid, input int sts, input string tag);
    int lat, to, need, cyc, n, r1, s0, busy_bad;
    bit id_succ, ts_succ;
    lat = lat_of(k);
    to  = to_of(k);
    id_val[k] = idv; ts_val[k] = tsv; stall_id[k] = sid; stall_ts[k] = sts;
    need    = sid + 1 + lat;
    id_succ = (need <= to);
    cyc     = 1 + (id_succ ? need : to);
    ts_succ = 1'b0;
    if (id_succ) begin
      need    = sts + 1 + lat;
      ts_succ = (need <= to);
      cyc     = cyc + (ts_succ ? need : to);
    end
    r1 = rd1_cnt[k]; s0 = stab_err[k]; busy_bad = 0;
    @(negedge clock); start[k] = 1'b1;
    @(negedge clock); start[k] = 1'b0;
    n = 1;
    while (!done[k] && n < 400) begin
      if (busy[k] !== 1'b1) busy_bad++;
      @(negedge clock); n++;
    end
    checks++;
    if (done[k] !== 1'b1) begin failures++; $display("FAIL %s done_seen: got no done within %0d cycles, required cycle %0d", tag, n, cyc); end
    checks++;
    if (n != cyc) begin failures++; $display("FAIL %s done_cycle: got %0d required %0d", tag, n, cyc); end
    checks++;
    if (busy[k] !== 1'b1 || busy_bad != 0) begin failures++; $display("FAIL %s busy_during: done-cycle busy=%b low_cycles=%0d required 1/0", tag, busy[k], busy_bad); end
    @(negedge clock);
    checks++;
    if (done[k] !== 1'b0 || busy[k] !== 1'b0) begin failures++; $display("FAIL %s after_done: done=%b busy=%b required 0/0", tag, done[k], busy[k]); end
    checks++;
    if (id_ok[k] !== (id_succ && idv == EXP_ID)) begin failures++; $display("FAIL %s id_ok: got %b required %b", tag, id_ok[k], id_succ && idv == EXP_ID); end
    checks++;
    if (ts_ok[k] !== (ts_succ && tsv == EXP_TS)) begin failures++; $display("FAIL %s ts_ok: got %b required %b", tag, ts_ok[k], ts_succ && tsv == EXP_TS); end
    checks++;
    if (terr[k] !== !(id_succ && ts_succ)) begin failures++; $display("FAIL %s timeout_err: got %b required %b", tag, terr[k], !(id_succ && ts_succ)); end
    checks++;
    if (cid[k] !== (id_succ ? idv : 32'd0)) begin failures++; $display("FAIL %s captured_id: got %h required %h", tag, cid[k], id_succ ? idv : 32'd0); end
    checks++;
    if (cts[k] !== (ts_succ ? tsv : 32'd0)) begin failures++; $display("FAIL %s captured_ts: got %h required %h", tag, cts[k], ts_succ ? tsv : 32'd0); end
    checks++;
    if ((rd1_cnt[k] != r1) != id_succ) begin failures++; $display("FAIL %s addr1_read_issued: got %0d required %b", tag, rd1_cnt[k] - r1, id_succ); end
    checks++;
    if (stab_err[k] != s0) begin failures++; $display("FAIL %s stall_stability: got %0d violations required 0", tag, stab_err[k] - s0); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin start[k] = 1'b0; stall_id[k] = 0; stall_ts[k] = 0; rd1_cnt[k] = 0; stab_err[k] = 0; end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({addr[k], rd[k], busy[k], done[k], id_ok[k], ts_ok[k], terr[k], cid[k], cts[k]} !== 71'd0) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: a=%b r=%b b=%b d=%b io=%b to=%b te=%b id=%h ts=%h required all 0",
                 k, addr[k], rd[k], busy[k], done[k], id_ok[k], ts_ok[k], terr[k], cid[k], cts[k]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_nominal();
    run_seq(0, EXP_ID, EXP_TS, 0, 0, "nominal");
    run_seq(0, EXP_ID, 32'h5230C1E0, 0, 0, "bad_ts");
    run_seq(1, EXP_ID, EXP_TS, 3, 3, "stall_lat2");
  endtask

  task automatic test_timeout();
    run_seq(2, EXP_ID, EXP_TS, 1000, 0, "timeout_id");
    run_seq(2, EXP_ID, EXP_TS, 3, 3, "capture_wins");
    run_seq(2, EXP_ID, EXP_TS, 0, 4, "timeout_ts");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int k;
      logic [31:0] idv, tsv;
      k   = $urandom_range(0, 2);
      idv = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      tsv = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      run_seq(k, idv, tsv, $urandom_range(0, 5), $urandom_range(0, 5), $sformatf("random%0d_k%0d", i, k));
    end
  endtask

  task automatic test_reset_mid();
    int n, dn;
    id_val[1] = EXP_ID; ts_val[1] = EXP_TS; stall_id[1] = 0; stall_ts[1] = 0;
    @(negedge clock); start[1] = 1'b1;
    @(negedge clock); start[1] = 1'b0;
    n = 0;
    while (!(rd[1] && addr[1] && !wr[1]) && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (!(rd[1] && addr[1])) begin failures++; $display("FAIL reset_mid_reach_ts: got no address-1 read within %0d cycles, required one", n); end
    @(negedge clock);
    reset_n = 1'b0;
    dn = 0;
    repeat (3) begin
      #1;
      checks++;
      if ({addr[1], rd[1], busy[1], done[1], id_ok[1], ts_ok[1], terr[1], cid[1], cts[1]} !== 71'd0) begin
        failures++;
        $display("FAIL reset_mid_outputs: a=%b r=%b b=%b d=%b id=%h required all 0", addr[1], rd[1], busy[1], done[1], cid[1]);
      end
      @(negedge clock);
    end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clock); if (done[1]) dn++; end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL reset_mid_no_done: got %0d done pulses required 0", dn); end
    run_seq(1, EXP_ID, EXP_TS, 0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int dn, misplaced, b;
    stall_id[0] = 0; stall_ts[0] = 0; id_val[0] = EXP_ID; ts_val[0] = EXP_TS;
    @(negedge clock); start[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0;
    @(negedge clock); start[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0;
    checks++;
    if (done[0] !== 1'b1) begin failures++; $display("FAIL ignore_busy_done: got %b required 1", done[0]); end
    b = 0;
    repeat (4) begin @(negedge clock); if (busy[0] || done[0]) b++; end
    checks++;
    if (b != 0) begin failures++; $display("FAIL ignore_busy_restart: got %0d busy cycles required 0", b); end
    // Held start: each sequence is 3 busy cycles plus the IDLE cycle that samples start.
    start[0] = 1'b1;
    dn = 0; misplaced = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (done[0]) begin dn++; if (i % 4 != 3) misplaced++; end
    end
    start[0] = 1'b0;
    checks++;
    if (dn != 4 || misplaced != 0) begin failures++; $display("FAIL held_start: got %0d done pulses (%0d misplaced) required 4 (0)", dn, misplaced); end
    repeat (2) @(negedge clock);
    checks++;
    if (busy[0] !== 1'b0 || id_ok[0] !== 1'b1 || ts_ok[0] !== 1'b1) begin
      failures++; $display("FAIL held_start_final: busy=%b id_ok=%b ts_ok=%b required 0/1/1", busy[0], id_ok[0], ts_ok[0]);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
